// File: rtl/sfp_vec3_cross_seq.sv
// Q(IW).(QW) vec3 cross product a x b using one shared signed multiplier,
// sequenced over six cycles by an IDLE/MUL/DONE FSM with valid/ready handshakes.
module sfp_vec3_cross_seq #(
  parameter int IW    = 16,
  parameter int QW    = 16,
  parameter int ROUND = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [IW+QW-1:0]     a_i [3],
  input  logic [IW+QW-1:0]     b_i [3],
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [IW+QW-1:0]     out_o [3],
  output logic                 busy_o
);

  localparam int W = IW + QW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     step_q, step_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   out_q [3];
  logic [W-1:0]   out_d [3];
  logic [W-1:0]   op_a_q [3];
  logic [W-1:0]   op_a_d [3];
  logic [W-1:0]   op_b_q [3];
  logic [W-1:0]   op_b_d [3];
  logic [W-1:0]   mul_x_s, mul_y_s, prod_s, diff_s;

  // Full-width signed product, optional half-up rounding, arithmetic shift, wrap to W bits.
  function automatic logic [W-1:0] fx_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] full;
    logic signed [2*W-1:0] rnd;
    logic signed [2*W-1:0] shifted;
    full = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
    rnd  = '0;
    if (ROUND != 0) begin
      rnd[QW-1] = 1'b1;
    end else begin
      rnd = '0;
    end
    shifted = (full + rnd) >>> QW;
    return shifted[W-1:0];
  endfunction

  // Operand pair selected for the shared multiplier at each step.
  always_comb begin
    mul_x_s = '0;
    mul_y_s = '0;
    case (step_q)
      3'd0:    begin mul_x_s = op_a_q[1]; mul_y_s = op_b_q[2]; end
      3'd1:    begin mul_x_s = op_a_q[2]; mul_y_s = op_b_q[1]; end
      3'd2:    begin mul_x_s = op_a_q[2]; mul_y_s = op_b_q[0]; end
      3'd3:    begin mul_x_s = op_a_q[0]; mul_y_s = op_b_q[2]; end
      3'd4:    begin mul_x_s = op_a_q[0]; mul_y_s = op_b_q[1]; end
      3'd5:    begin mul_x_s = op_a_q[1]; mul_y_s = op_b_q[0]; end
      default: begin mul_x_s = '0;        mul_y_s = '0;        end
    endcase
  end

  assign prod_s = fx_mul(mul_x_s, mul_y_s);
  assign diff_s = acc_q - prod_s;

  // FSM next state, step sequencing and datapath register updates.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    out_d   = out_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          op_a_d  = a_i;
          op_b_d  = b_i;
          step_d  = 3'd0;
          state_d = S_MUL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        // Even steps load the minuend product; odd steps finish one component.
        case (step_q)
          3'd0, 3'd2, 3'd4: acc_d    = prod_s;
          3'd1:             out_d[0] = diff_s;
          3'd3:             out_d[1] = diff_s;
          3'd5:             out_d[2] = diff_s;
          default:          acc_d    = acc_q;
        endcase
        if (step_q == 3'd5) begin
          step_d  = 3'd0;
          state_d = S_DONE;
        end else begin
          step_d  = step_q + 3'd1;
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        step_d  = 3'd0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      step_q  <= 3'd0;
      acc_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        out_q[i]  <= '0;
        op_a_q[i] <= '0;
        op_b_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign out_o       = out_q;

endmodule

// File: tb/tb_sfp_vec3_cross_seq.sv
// Bench for sfp_vec3_cross_seq: truncating and rounding instances share stimulus
// and are compared against a 64-bit integer model of the cross product.
module tb_sfp_vec3_cross_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a [3];
  logic [31:0] b [3];
  logic        in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
  logic [31:0] o0 [3];
  logic [31:0] o1 [3];
  logic [31:0] ta [3];
  logic [31:0] tb [3];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sfp_vec3_cross_seq #(.IW(16), .QW(16), .ROUND(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .a_i(a), .b_i(b), .out_valid_o(out_valid0), .out_ready_i(out_ready),
    .out_o(o0), .busy_o(busy0));

  sfp_vec3_cross_seq #(.IW(16), .QW(16), .ROUND(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .a_i(a), .b_i(b), .out_valid_o(out_valid1), .out_ready_i(out_ready),
    .out_o(o1), .busy_o(busy1));

  function automatic logic [95:0] pack3(input logic [31:0] v [3]);
    return {v[0], v[1], v[2]};
  endfunction

  // Reference fixed-point product: exact 64-bit product, optional +0.5 lsb, floor shift.
  function automatic logic [31:0] mp(input logic [31:0] x, input logic [31:0] y, input int rnd);
    longint pr;
    pr = longint'($signed(x)) * longint'($signed(y));
    if (rnd != 0) pr = pr + 64'sd32768;
    pr = pr >>> 16;
    return pr[31:0];
  endfunction

  function automatic logic [95:0] mcross(input logic [31:0] x [3], input logic [31:0] y [3], input int rnd);
    logic [31:0] c0, c1, c2;
    c0 = mp(x[1], y[2], rnd) - mp(x[2], y[1], rnd);
    c1 = mp(x[2], y[0], rnd) - mp(x[0], y[2], rnd);
    c2 = mp(x[0], y[1], rnd) - mp(x[1], y[0], rnd);
    return {c0, c1, c2};
  endfunction

  function automatic logic [31:0] rv();
    if ($urandom_range(0, 1) == 1) return $urandom();
    else return 32'($urandom_range(0, 32'h000FFFFF)) - 32'h00080000;
  endfunction

  task automatic do_accept();
    int n;
    n = 0;
    while (in_ready0 !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    a = ta; b = tb; in_valid = 1'b1; out_ready = 1'b0;
    checks++;
    if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready got %b/%b exp 1", in_ready0, in_ready1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin a[i] = $urandom(); b[i] = $urandom(); end
  endtask

  task automatic start_and_wait(input string nm);
    int  lat;
    bit  held;
    do_accept();
    lat  = 0;
    held = 1'b1;
    while (out_valid0 !== 1'b1 && lat < 20) begin
      if (in_ready0 !== 1'b0 || busy0 !== 1'b1 || in_ready1 !== 1'b0) held = 1'b0;
      @(posedge clk); #1; lat++;
      for (int i = 0; i < 3; i++) begin a[i] = $urandom(); b[i] = $urandom(); end
    end
    checks++;
    if (lat != 6 || out_valid1 !== 1'b1) begin
      errors++;
      $display("FAIL %s latency got %0d (valid1 %b) exp 6", nm, lat, out_valid1);
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL %s ready_low_in_mul got in_ready=1 or busy=0 exp in_ready=0 busy=1", nm);
    end
  endtask

  task automatic finish_handshake(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || busy0 !== 1'b0 || out_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL %s handshake got valid=%b ready=%b busy=%b exp 0 1 0", nm, out_valid0, in_ready0, busy0);
    end
  endtask

  task automatic run_one(input string nm, input logic [95:0] e0, input logic [95:0] e1);
    start_and_wait(nm);
    checks++;
    if (pack3(o0) !== e0) begin
      errors++;
      $display("FAIL %s trunc got %h exp %h", nm, pack3(o0), e0);
    end
    checks++;
    if (pack3(o1) !== e1) begin
      errors++;
      $display("FAIL %s round got %h exp %h", nm, pack3(o1), e1);
    end
    finish_handshake(nm);
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin a[i] = 32'h0; b[i] = 32'h0; end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    checks++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || busy0 !== 1'b0 || pack3(o0) !== 96'h0 || pack3(o1) !== 96'h0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b busy=%b out=%h exp 1 0 0 0", in_ready0, out_valid0, busy0, pack3(o0));
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b vld=%b busy=%b exp 1 0 0", in_ready0, out_valid0, busy0);
    end
  endtask

  task automatic test_fixed();
    ta = '{32'h00010000, 32'h0, 32'h0}; tb = '{32'h0, 32'h00010000, 32'h0};
    run_one("basis", {32'h0, 32'h0, 32'h00010000}, {32'h0, 32'h0, 32'h00010000});
    ta = '{32'h00020000, 32'h00030000, 32'h00040000}; tb = '{32'h00050000, 32'h00060000, 32'h00070000};
    run_one("general", {32'hFFFD0000, 32'h00060000, 32'hFFFD0000}, {32'hFFFD0000, 32'h00060000, 32'hFFFD0000});
    ta = '{32'h0, 32'h00000001, 32'h0}; tb = '{32'h0, 32'h0, 32'h00008000};
    run_one("round_a", {32'h0, 32'h0, 32'h0}, {32'h00000001, 32'h0, 32'h0});
    ta = '{32'h0, 32'hFFFFFFFF, 32'h0};
    run_one("round_b", {32'hFFFFFFFF, 32'h0, 32'h0}, {32'h0, 32'h0, 32'h0});
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 3; i++) begin ta[i] = rv(); tb[i] = rv(); end
      run_one("random", mcross(ta, tb, 0), mcross(ta, tb, 1));
    end
  endtask

  task automatic test_backpressure();
    logic [95:0] s0, s1;
    bit          stable;
    int          extra;
    for (int i = 0; i < 3; i++) begin ta[i] = rv(); tb[i] = rv(); end
    start_and_wait("bp");
    s0 = pack3(o0); s1 = pack3(o1);
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = ~in_valid;
      for (int i = 0; i < 3; i++) begin a[i] = $urandom(); b[i] = $urandom(); end
      @(posedge clk); #1;
      if (pack3(o0) !== s0 || pack3(o1) !== s1 || out_valid0 !== 1'b1 || in_ready0 !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_hold got change during stall exp stable out=%h", s0);
    end
    checks++;
    if (s0 !== mcross(ta, tb, 0) || s1 !== mcross(ta, tb, 1)) begin
      errors++;
      $display("FAIL bp_value got %h/%h exp %h/%h", s0, s1, mcross(ta, tb, 0), mcross(ta, tb, 1));
    end
    finish_handshake("bp");
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (out_valid0 === 1'b1 || busy0 === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL bp_single got %0d extra busy/valid cycles exp 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] wa [3];
    logic [31:0] wb [3];
    int          acc_cyc [$];
    logic [95:0] r0 [$];
    logic [95:0] r1 [$];
    for (int i = 0; i < 3; i++) begin va[i] = rv(); vb[i] = rv(); wa[i] = rv(); wb[i] = rv(); end
    a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (acc_cyc.size() == 2 && in_ready0 !== 1'b1) in_valid = 1'b0;
      if (acc_cyc.size() == 1) begin a = wa; b = wb; end
      if (in_valid === 1'b1 && in_ready0 === 1'b1) acc_cyc.push_back(cyc);
      if (out_valid0 === 1'b1) begin r0.push_back(pack3(o0)); r1.push_back(pack3(o1)); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (acc_cyc.size() != 2) begin
      errors++;
      $display("FAIL b2b_accepts got %0d exp 2", acc_cyc.size());
    end else begin
      checks++;
      if (acc_cyc[1] - acc_cyc[0] != 8) begin
        errors++;
        $display("FAIL b2b_spacing got %0d exp 8", acc_cyc[1] - acc_cyc[0]);
      end
    end
    checks++;
    if (r0.size() != 2) begin
      errors++;
      $display("FAIL b2b_results got %0d exp 2", r0.size());
    end else begin
      checks++;
      if (r0[0] !== mcross(va, vb, 0) || r1[0] !== mcross(va, vb, 1)) begin
        errors++;
        $display("FAIL b2b_first got %h/%h exp %h/%h", r0[0], r1[0], mcross(va, vb, 0), mcross(va, vb, 1));
      end
      checks++;
      if (r0[1] !== mcross(wa, wb, 0) || r1[1] !== mcross(wa, wb, 1)) begin
        errors++;
        $display("FAIL b2b_second got %h/%h exp %h/%h", r0[1], r1[1], mcross(wa, wb, 0), mcross(wa, wb, 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    ta = '{32'h00020000, 32'h00030000, 32'h00040000}; tb = '{32'h00050000, 32'h00060000, 32'h00070000};
    do_accept();
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || busy0 !== 1'b0 || pack3(o0) !== 96'h0 || pack3(o1) !== 96'h0) begin
      errors++;
      $display("FAIL rst_mid got rdy=%b vld=%b busy=%b out=%h exp 1 0 0 0", in_ready0, out_valid0, busy0, pack3(o0));
    end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || out_valid1 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_mid_idle got %0d bad cycles exp 0", bad);
    end
    for (int i = 0; i < 3; i++) begin ta[i] = rv(); tb[i] = rv(); end
    run_one("after_rst", mcross(ta, tb, 0), mcross(ta, tb, 1));
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
